// File: rtl/button_conditioner.sv
// Pushbutton front-end: synchronizes and debounces raw pins, then derives press pulses,
// long-press flags and auto-repeat command pulses, independently per channel.
module button_conditioner #(
   parameter int               N_BTN           = 4,
   parameter int               DEBOUNCE_CYCLES = 1_000_000,
   parameter int               HOLD_CYCLES     = 50_000_000,
   parameter int               REPEAT_CYCLES   = 25_000_000,
   parameter logic [N_BTN-1:0] REPEAT_MASK     = 4'b1100
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [N_BTN-1:0]     btn_raw,
   output logic [N_BTN-1:0]     btn_level,
   output logic [N_BTN-1:0]     press_pulse,
   output logic [N_BTN-1:0]     cmd_pulse,
   output logic [N_BTN-1:0]     long_press,
   output logic [2*N_BTN-1:0]   fsm_state
);

   localparam int DB_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam int HOLD_W = (HOLD_CYCLES > 1)     ? $clog2(HOLD_CYCLES)     : 1;
   localparam int REP_W  = (REPEAT_CYCLES > 1)   ? $clog2(REPEAT_CYCLES)   : 1;

   localparam logic [DB_W-1:0]   DB_TERM   = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [HOLD_W-1:0] HOLD_TERM = HOLD_W'(HOLD_CYCLES - 1);
   localparam logic [REP_W-1:0]  REP_TERM  = REP_W'(REPEAT_CYCLES - 1);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_HOLD   = 2'd1;
   localparam logic [1:0] ST_REPEAT = 2'd2;

   for (genvar i = 0; i < N_BTN; i++) begin : g_ch
      logic [1:0]        sync_q;
      logic [DB_W-1:0]   db_cnt;
      logic              level_q;
      logic [HOLD_W-1:0] hold_cnt;
      logic [REP_W-1:0]  rep_cnt;
      logic [1:0]        state;
      logic              press_q;
      logic              cmd_q;
      logic              long_q;
      logic              s;
      logic              differ;
      logic              accept;
      logic              rise;
      logic              fall;

      assign s      = sync_q[1];
      assign differ = (s != level_q);
      assign accept = differ && (db_cnt == DB_TERM);
      // rise/fall describe the level change being committed on this edge, so the
      // FSM outputs line up with the cycle in which btn_level changes.
      assign rise   = accept && s;
      assign fall   = accept && !s;

      always_ff @(posedge clk or negedge reset) begin
         if (!reset) begin
            sync_q <= 2'b00;
         end else begin
            sync_q <= {sync_q[0], btn_raw[i]};
         end
      end

      always_ff @(posedge clk or negedge reset) begin
         if (!reset) begin
            db_cnt  <= '0;
            level_q <= 1'b0;
         end else if (!differ) begin
            db_cnt <= '0;
         end else if (accept) begin
            level_q <= s;
            db_cnt  <= '0;
         end else begin
            db_cnt <= db_cnt + 1'b1;
         end
      end

      always_ff @(posedge clk or negedge reset) begin
         if (!reset) begin
            state    <= ST_IDLE;
            hold_cnt <= '0;
            rep_cnt  <= '0;
            press_q  <= 1'b0;
            cmd_q    <= 1'b0;
            long_q   <= 1'b0;
         end else begin
            press_q <= 1'b0;
            cmd_q   <= 1'b0;
            // Release wins over any pulse falling due on the same edge.
            if (fall) begin
               state    <= ST_IDLE;
               hold_cnt <= '0;
               rep_cnt  <= '0;
               long_q   <= 1'b0;
            end else begin
               case (state)
                  ST_IDLE: begin
                     if (rise) begin
                        press_q  <= 1'b1;
                        cmd_q    <= 1'b1;
                        hold_cnt <= '0;
                        state    <= ST_HOLD;
                     end
                  end
                  ST_HOLD: begin
                     if (hold_cnt == HOLD_TERM) begin
                        long_q   <= 1'b1;
                        cmd_q    <= REPEAT_MASK[i];
                        hold_cnt <= '0;
                        rep_cnt  <= '0;
                        state    <= ST_REPEAT;
                     end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                     end
                  end
                  ST_REPEAT: begin
                     if (rep_cnt == REP_TERM) begin
                        cmd_q   <= REPEAT_MASK[i];
                        rep_cnt <= '0;
                     end else begin
                        rep_cnt <= rep_cnt + 1'b1;
                     end
                  end
                  default: state <= ST_IDLE;
               endcase
            end
         end
      end

      assign btn_level[i]        = level_q;
      assign press_pulse[i]      = press_q;
      assign cmd_pulse[i]        = cmd_q;
      assign long_press[i]       = long_q;
      assign fsm_state[2*i +: 2] = state;
   end

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with short timing parameters
// (debounce 4, hold 10, repeat 3, repeat on inc/dec only).
module tb_button_conditioner;

   logic       clk;
   logic       reset;
   logic [3:0] btn_raw;
   logic [3:0] btn_level;
   logic [3:0] press_pulse;
   logic [3:0] cmd_pulse;
   logic [3:0] long_press;
   logic [7:0] fsm_state;

   int n_vec;
   int n_err;

   button_conditioner #(
      .N_BTN(4),
      .DEBOUNCE_CYCLES(4),
      .HOLD_CYCLES(10),
      .REPEAT_CYCLES(3),
      .REPEAT_MASK(4'b1100)
   ) dut (
      .clk(clk),
      .reset(reset),
      .btn_raw(btn_raw),
      .btn_level(btn_level),
      .press_pulse(press_pulse),
      .cmd_pulse(cmd_pulse),
      .long_press(long_press),
      .fsm_state(fsm_state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      logic [3:0] exp_cmd;
      logic [3:0] exp_long;
      logic [3:0] exp_lvl;
      n_vec   = 0;
      n_err   = 0;
      reset   = 1'b0;
      btn_raw = 4'hF;

      // Reset held with all buttons pressed.
      tick(3);
      check("rst_level", 8'(btn_level), 8'h00);
      check("rst_press", 8'(press_pulse), 8'h00);
      check("rst_cmd", 8'(cmd_pulse), 8'h00);
      check("rst_long", 8'(long_press), 8'h00);
      check("rst_state", fsm_state, 8'h00);

      // Release reset: held buttons accepted 6 cycles later.
      reset = 1'b1;
      tick(5);
      check("post_rst_level_early", 8'(btn_level), 8'h00);
      check("post_rst_press_early", 8'(press_pulse), 8'h00);
      tick(1);
      check("post_rst_level", 8'(btn_level), 8'h0F);
      check("post_rst_press", 8'(press_pulse), 8'h0F);
      check("post_rst_cmd", 8'(cmd_pulse), 8'h0F);
      check("post_rst_long", 8'(long_press), 8'h00);
      check("post_rst_state", fsm_state, 8'h55);
      tick(1);
      check("post_rst_press_1cyc", 8'(press_pulse), 8'h00);
      check("post_rst_cmd_1cyc", 8'(cmd_pulse), 8'h00);

      btn_raw = 4'h0;
      tick(6);
      check("release_all_level", 8'(btn_level), 8'h00);
      check("release_all_long", 8'(long_press), 8'h00);
      check("release_all_state", fsm_state, 8'h00);

      // Bounce on inc: 2-cycle glitches must be discarded.
      for (int k = 0; k < 10; k++) begin
         btn_raw[2] = (k % 2 == 0);
         for (int j = 0; j < 2; j++) begin
            tick(1);
            check("bounce_press", 8'(press_pulse), 8'h00);
            check("bounce_level", 8'(btn_level), 8'h00);
         end
      end
      btn_raw[2] = 1'b1;
      tick(5);
      check("bounce_level_early", 8'(btn_level), 8'h00);
      tick(1);
      check("bounce_level", 8'(btn_level), 8'h04);
      check("bounce_press_final", 8'(press_pulse), 8'h04);
      check("bounce_cmd_final", 8'(cmd_pulse), 8'h04);

      // Auto-repeat on inc, then release so the fall lands on a due repeat slot.
      for (int t = 1; t <= 46; t++) begin
         tick(1);
         exp_cmd  = (t < 46 && t >= 10 && (t - 10) % 3 == 0) ? 4'b0100 : 4'b0000;
         exp_long = (t >= 10 && t < 46) ? 4'b0100 : 4'b0000;
         exp_lvl  = (t < 46) ? 4'b0100 : 4'b0000;
         check("rep_cmd", 8'(cmd_pulse), 8'(exp_cmd));
         check("rep_long", 8'(long_press), 8'(exp_long));
         check("rep_level", 8'(btn_level), 8'(exp_lvl));
         check("rep_press", 8'(press_pulse), 8'h00);
         if (t == 40) btn_raw[2] = 1'b0;
      end
      check("rep_release_state", fsm_state, 8'h00);
      tick(3);
      check("rep_after_release_cmd", 8'(cmd_pulse), 8'h00);

      // Edit: long press but no repeat.
      btn_raw[0] = 1'b1;
      tick(5);
      check("edit_level_early", 8'(btn_level), 8'h00);
      tick(1);
      check("edit_press", 8'(press_pulse), 8'h01);
      check("edit_cmd", 8'(cmd_pulse), 8'h01);
      for (int t = 1; t <= 46; t++) begin
         tick(1);
         exp_long = (t >= 10 && t < 46) ? 4'b0001 : 4'b0000;
         exp_lvl  = (t < 46) ? 4'b0001 : 4'b0000;
         check("edit_cmd_hold", 8'(cmd_pulse), 8'h00);
         check("edit_long", 8'(long_press), 8'(exp_long));
         check("edit_level", 8'(btn_level), 8'(exp_lvl));
         if (t == 10) check("edit_state_repeat", fsm_state, 8'h02);
         if (t == 40) btn_raw[0] = 1'b0;
      end
      check("edit_release_state", fsm_state, 8'h00);

      // Fresh press on inc after the boundary release, then hold into repeat.
      btn_raw[2] = 1'b1;
      tick(5);
      check("fresh_press_early", 8'(press_pulse), 8'h00);
      tick(1);
      check("fresh_press", 8'(press_pulse), 8'h04);
      check("fresh_cmd", 8'(cmd_pulse), 8'h04);
      tick(11);
      check("pre_rst_state", fsm_state, 8'h20);
      check("pre_rst_long", 8'(long_press), 8'h04);

      // Asynchronous reset in REPEAT.
      #2 reset = 1'b0;
      #1;
      check("async_rst_level", 8'(btn_level), 8'h00);
      check("async_rst_long", 8'(long_press), 8'h00);
      check("async_rst_cmd", 8'(cmd_pulse), 8'h00);
      check("async_rst_state", fsm_state, 8'h00);
      btn_raw = 4'h0;
      tick(2);
      reset = 1'b1;
      tick(3);

      // Simultaneous inc + dec press.
      btn_raw = 4'b1100;
      tick(5);
      check("simul_cmd_early", 8'(cmd_pulse), 8'h00);
      tick(1);
      check("simul_cmd", 8'(cmd_pulse), 8'h0C);
      check("simul_press", 8'(press_pulse), 8'h0C);
      check("simul_level", 8'(btn_level), 8'h0C);
      tick(1);
      check("simul_cmd_1cyc", 8'(cmd_pulse), 8'h00);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
